// File: rtl/mips_mem_bus_arbiter.sv
// Two-master, one-slave Avalon-style bus arbiter.
// m0 is the CPU data port, m1 is the instruction-fetch port. One transfer
// is in flight at a time: IDLE arbitrates (round-robin on ties), BUS
// forwards the granted master to the slave until acceptance, and RDWAIT
// counts out the fixed slave read latency before strobing readdatavalid.
//
// Handshake: a master request (read or write high) is accepted on the
// rising edge where it is granted, the arbiter is in BUS and s_waitrequest
// is low. Any requesting master that is not being accepted in a cycle sees
// waitrequest high; a master with no request always sees waitrequest low.
// readdatavalid is a single-cycle strobe qualifying the broadcast readdata.
module mips_mem_bus_arbiter #(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUS    = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t              state, state_nx;
    logic                grant, grant_nx;
    logic                last_grant, last_grant_nx;
    logic [2:0]          cnt, cnt_nx;

    logic                req0, req1;
    logic                g_read, g_write, g_req;
    logic [ADDR_W-1:0]   g_address;
    logic [DATA_W-1:0]   g_writedata;
    logic [DATA_W/8-1:0] g_byteenable;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Select the granted master's request fields
    always_comb begin
        g_read       = grant ? m1_read       : m0_read;
        g_write      = grant ? m1_write      : m0_write;
        g_address    = grant ? m1_address    : m0_address;
        g_writedata  = grant ? m1_writedata  : m0_writedata;
        g_byteenable = grant ? m1_byteenable : m0_byteenable;
        g_req        = g_read | g_write;
    end

    // State, grant and latency counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= 3'd0;
        end else begin
            state      <= state_nx;
            grant      <= grant_nx;
            last_grant <= last_grant_nx;
            cnt        <= cnt_nx;
        end
    end

    // Next-state: arbitrate in IDLE, wait for acceptance in BUS, count latency in RDWAIT
    always_comb begin
        state_nx      = state;
        grant_nx      = grant;
        last_grant_nx = last_grant;
        cnt_nx        = cnt;
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    // On a tie the master that did not win last time goes next
                    grant_nx      = (req0 & req1) ? ~last_grant : req1;
                    last_grant_nx = grant_nx;
                    state_nx      = BUS;
                end
            end
            BUS: begin
                if (!g_req) begin
                    state_nx = IDLE;
                end else if (!s_waitrequest) begin
                    if (g_write) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = RDWAIT;
                        cnt_nx   = 3'(READ_LATENCY);
                    end
                end
            end
            RDWAIT: begin
                cnt_nx = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Slave-side mux, master stalls and read-data strobes
    always_comb begin
        s_address        = '0;
        s_writedata      = '0;
        s_byteenable     = '0;
        s_read           = 1'b0;
        s_write          = 1'b0;
        m0_readdatavalid = 1'b0;
        m1_readdatavalid = 1'b0;
        if (state == BUS) begin
            s_address    = g_address;
            s_writedata  = g_writedata;
            s_byteenable = g_byteenable;
            // A simultaneous read and write is treated as a write
            s_read       = g_read & ~g_write;
            s_write      = g_write;
        end
        if (state == RDWAIT && cnt == 3'd1) begin
            m0_readdatavalid = ~grant;
            m1_readdatavalid = grant;
        end
        m0_waitrequest = req0 & ~((state == BUS) & ~grant & ~s_waitrequest);
        m1_waitrequest = req1 & ~((state == BUS) &  grant & ~s_waitrequest);
    end

    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;
    assign dbg_state   = state;

endmodule

// File: tb/tb_mips_mem_bus_arbiter.sv
// Bench for mips_mem_bus_arbiter: one instance with READ_LATENCY=1 (a_*) and
// one with READ_LATENCY=3 (b_*) share the same master and slave stimulus.
// A transaction-level model (owner / cycles-to-data) predicts every output
// each cycle; directed scenarios add constant checks on top.
module tb_mips_mem_bus_arbiter;

    localparam logic [1:0] DBG_IDLE = 2'd0;

    // clock / reset
    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // shared stimulus
    logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        s_waitrequest;
    logic [31:0] s_readdata;

    // instance a (latency 1) outputs
    logic [31:0] a_s_address, a_s_writedata, a_m0_readdata, a_m1_readdata;
    logic [3:0]  a_s_byteenable;
    logic        a_s_read, a_s_write, a_m0_waitrequest, a_m1_waitrequest;
    logic        a_m0_readdatavalid, a_m1_readdatavalid;
    logic [1:0]  a_dbg_state;
    // instance b (latency 3) outputs
    logic [31:0] b_s_address, b_s_writedata, b_m0_readdata, b_m1_readdata;
    logic [3:0]  b_s_byteenable;
    logic        b_s_read, b_s_write, b_m0_waitrequest, b_m1_waitrequest;
    logic        b_m0_readdatavalid, b_m1_readdatavalid;
    logic [1:0]  b_dbg_state;

    mips_mem_bus_arbiter #(.READ_LATENCY(1), .ADDR_W(32), .DATA_W(32)) u_dut_a (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(a_m0_waitrequest), .m0_readdata(a_m0_readdata),
        .m0_readdatavalid(a_m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(a_m1_waitrequest), .m1_readdata(a_m1_readdata),
        .m1_readdatavalid(a_m1_readdatavalid),
        .s_address(a_s_address), .s_read(a_s_read), .s_write(a_s_write),
        .s_writedata(a_s_writedata), .s_byteenable(a_s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .dbg_state(a_dbg_state)
    );

    mips_mem_bus_arbiter #(.READ_LATENCY(3), .ADDR_W(32), .DATA_W(32)) u_dut_b (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(b_m0_waitrequest), .m0_readdata(b_m0_readdata),
        .m0_readdatavalid(b_m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(b_m1_waitrequest), .m1_readdata(b_m1_readdata),
        .m1_readdatavalid(b_m1_readdatavalid),
        .s_address(b_s_address), .s_read(b_s_read), .s_write(b_s_write),
        .s_writedata(b_s_writedata), .s_byteenable(b_s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .dbg_state(b_dbg_state)
    );

    // scoreboard bookkeeping
    int n_checks = 0;
    int n_errors = 0;
    int cnt_swr[2];
    int cnt_srd[2];
    int cnt_rdv[2][2];
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    // reference model: who owns the bus, and how many cycles until read data
    int lat[2] = '{1, 3};
    int owner[2];      // -1: nobody, arbitration pending
    int last_win[2];   // master that won the previous arbitration
    int rd_left[2];    // >0: read accepted, data strobe when it reaches 1

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic f_read(input int n);
        return (n == 1) ? m1_read : m0_read;
    endfunction
    function automatic logic f_write(input int n);
        return (n == 1) ? m1_write : m0_write;
    endfunction
    function automatic logic [31:0] f_addr(input int n);
        return (n == 1) ? m1_address : m0_address;
    endfunction
    function automatic logic [31:0] f_wdata(input int n);
        return (n == 1) ? m1_writedata : m0_writedata;
    endfunction
    function automatic logic [3:0] f_be(input int n);
        return (n == 1) ? m1_byteenable : m0_byteenable;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            owner[d]    = -1;
            last_win[d] = 1;
            rd_left[d]  = 0;
        end
    endtask

    // advance the model across one rising edge using the inputs held this cycle
    task automatic model_update();
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                owner[d] = -1; last_win[d] = 1; rd_left[d] = 0;
            end else if (owner[d] < 0) begin
                logic r0, r1;
                r0 = m0_read | m0_write;
                r1 = m1_read | m1_write;
                if (r0 && r1)  owner[d] = 1 - last_win[d];
                else if (r0)   owner[d] = 0;
                else if (r1)   owner[d] = 1;
                if (owner[d] >= 0) last_win[d] = owner[d];
            end else if (rd_left[d] > 0) begin
                rd_left[d]--;
                if (rd_left[d] == 0) owner[d] = -1;
            end else begin
                int o;
                o = owner[d];
                if (!(f_read(o) | f_write(o)))  owner[d] = -1;
                else if (!s_waitrequest) begin
                    if (f_write(o)) owner[d] = -1;
                    else            rd_left[d] = lat[d];
                end
            end
        end
    endtask

    // compare one instance's outputs against the model for the current cycle
    task automatic check_dut(input int d,
                             input logic [31:0] sa, input logic [31:0] swd, input logic [3:0] sbe,
                             input logic srd, input logic swr,
                             input logic w0, input logic w1, input logic v0, input logic v1,
                             input logic [31:0] rd0, input logic [31:0] rd1);
        logic        active;
        int          o;
        logic [69:0] exp_bus;
        logic        exp_w [2];
        logic        exp_v [2];
        active = (owner[d] >= 0) && (rd_left[d] == 0);
        o = (owner[d] < 0) ? 0 : owner[d];
        if (active)
            exp_bus = {f_addr(o), f_wdata(o), f_be(o), f_read(o) & ~f_write(o), f_write(o)};
        else
            exp_bus = '0;
        chk($sformatf("d%0d_slave_bus", d), {sa, swd, sbe, srd, swr}, exp_bus);
        for (int n = 0; n < 2; n++) begin
            exp_w[n] = (f_read(n) | f_write(n)) & ~(active && o == n && !s_waitrequest);
            exp_v[n] = (owner[d] == n) && (rd_left[d] == 1);
        end
        chk($sformatf("d%0d_waitrequest", d), {w1, w0}, {exp_w[1], exp_w[0]});
        chk($sformatf("d%0d_readdatavalid", d), {v1, v0}, {exp_v[1], exp_v[0]});
        chk($sformatf("d%0d_readdata", d), {rd1, rd0}, {s_readdata, s_readdata});
        cnt_swr[d] += int'(swr);
        cnt_srd[d] += int'(srd);
        cnt_rdv[d][0] += int'(v0);
        cnt_rdv[d][1] += int'(v1);
        if (d == 0 && v0) got_q.push_back(32'd0);
        if (d == 0 && v1) got_q.push_back(32'd1);
    endtask

    // one clock: compare at the falling edge, step the model, return just after the rising edge
    task automatic step();
        @(negedge clk);
        check_dut(0, a_s_address, a_s_writedata, a_s_byteenable, a_s_read, a_s_write,
                  a_m0_waitrequest, a_m1_waitrequest, a_m0_readdatavalid, a_m1_readdatavalid,
                  a_m0_readdata, a_m1_readdata);
        check_dut(1, b_s_address, b_s_writedata, b_s_byteenable, b_s_read, b_s_write,
                  b_m0_waitrequest, b_m1_waitrequest, b_m0_readdatavalid, b_m1_readdatavalid,
                  b_m0_readdata, b_m1_readdata);
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_steps(input int n);
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
        s_waitrequest = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic assert_reset();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic clear_counts();
        for (int d = 0; d < 2; d++) begin
            cnt_swr[d] = 0; cnt_srd[d] = 0; cnt_rdv[d][0] = 0; cnt_rdv[d][1] = 0;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int hold;
        m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
        m0_byteenable = '0; m1_byteenable = '0;
        s_waitrequest = 1'b0; s_readdata = '0;
        clear_counts();
        assert_reset();
        @(posedge clk);
        #1;

        // reset holds the slave quiet even with a pending read
        m0_read = 1'b1; m0_address = 32'h0000_0100;
        #1;
        chk("rst_s_read", a_s_read, 1'b0);
        chk("rst_s_write", a_s_write, 1'b0);
        chk("rst_m0_rdv", a_m0_readdatavalid, 1'b0);
        chk("rst_state", a_dbg_state, DBG_IDLE);
        step(); step();
        reset = 1'b1;
        #1;
        chk("rel_idle_s_read", a_s_read, 1'b0);
        step();
        chk("rel_s_read_rise", a_s_read, 1'b1);
        step();
        idle_steps(6);

        // single write from m0
        clear_counts();
        m0_write = 1'b1; m0_address = 32'hBFC0_0030; m0_writedata = 32'h0000_00F3;
        m0_byteenable = 4'b0001;
        #1;
        chk("wr_wait_idle", a_m0_waitrequest, 1'b1);
        step();
        chk("wr_bus_fields", {a_s_write, a_s_address, a_s_writedata, a_s_byteenable},
            {1'b1, 32'hBFC0_0030, 32'h0000_00F3, 4'b0001});
        chk("wr_wait_bus", a_m0_waitrequest, 1'b0);
        step();
        idle_steps(4);
        chk("wr_swrite_cycles_a", cnt_swr[0], 1);
        chk("wr_swrite_cycles_b", cnt_swr[1], 1);

        // single read from m1
        clear_counts();
        s_readdata = 32'h3C08_BFC0;
        m1_read = 1'b1; m1_address = 32'hBFC0_0000;
        step(); step();
        m1_read = 1'b0;
        #1;
        chk("rd_m1_rdv", a_m1_readdatavalid, 1'b1);
        chk("rd_m1_data", a_m1_readdata, 32'h3C08_BFC0);
        chk("rd_m0_rdv", a_m0_readdatavalid, 1'b0);
        idle_steps(6);
        chk("rd_sread_cycles", cnt_srd[0], 1);
        chk("rd_m1_rdv_count_a", cnt_rdv[0][1], 1);
        chk("rd_m0_rdv_count_a", cnt_rdv[0][0], 0);
        chk("rd_m1_rdv_count_b", cnt_rdv[1][1], 1);

        // contention from reset: grants alternate m0, m1, m0, m1
        assert_reset();
        m0_read = 1'b1; m0_address = 32'h0000_1000;
        m1_read = 1'b1; m1_address = 32'h0000_2000;
        step();
        reset = 1'b1;
        clear_counts();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i % 2));
        for (int i = 0; i < 12; i++) step();
        chk("cont_m0_count", cnt_rdv[0][0], 2);
        chk("cont_m1_count", cnt_rdv[0][1], 2);
        chk("cont_order_len", got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0)
            chk("cont_order", got_q.pop_front(), exp_q.pop_front());
        idle_steps(8);

        // slave stall on an m1 write while m0 waits
        clear_counts();
        s_waitrequest = 1'b1;
        m1_write = 1'b1; m1_address = 32'hA000_0040; m1_writedata = 32'hCAFE_F00D;
        m1_byteenable = 4'hF;
        step();
        m0_read = 1'b1; m0_address = 32'h0000_1000;
        for (int i = 0; i < 4; i++) begin
            s_waitrequest = (i < 3);
            #1;
            chk("stall_hold", {a_s_write, a_s_address, a_s_writedata, a_m0_waitrequest},
                {1'b1, 32'hA000_0040, 32'hCAFE_F00D, 1'b1});
            step();
        end
        m1_write = 1'b0;
        #1;
        chk("stall_m0_wait_idle", a_m0_waitrequest, 1'b1);
        step();
        chk("stall_m0_granted", {a_s_read, a_s_address}, {1'b1, 32'h0000_1000});
        step();
        idle_steps(6);

        // reset while a latency-3 read is outstanding
        clear_counts();
        m0_read = 1'b1; m0_address = 32'h0000_2000;
        step(); step();
        m0_read = 1'b0;
        assert_reset();
        step(); step();
        chk("rdwait_rst_no_rdv_b", cnt_rdv[1][0], 0);
        chk("rdwait_rst_no_rdv_a", cnt_rdv[0][0], 0);
        reset = 1'b1;
        m0_read = 1'b1; m0_address = 32'h0000_3000;
        m1_read = 1'b1; m1_address = 32'h0000_4000;
        #1;
        chk("post_rst_idle", b_dbg_state, DBG_IDLE);
        step();
        chk("post_rst_grant_m0", {b_s_read, b_s_address}, {1'b1, 32'h0000_3000});
        step();
        idle_steps(8);

        // randomized traffic, stalls and occasional resets
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (!reset) begin
                if (hold == 0) reset = 1'b1;
                else hold--;
            end else if ($urandom_range(0, 199) == 0) begin
                assert_reset();
                hold = $urandom_range(0, 1);
            end
            if ($urandom_range(0, 3) == 0) begin
                {m0_write, m0_read} = 2'($urandom_range(0, 3));
                m0_address = $urandom; m0_writedata = $urandom;
                m0_byteenable = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 3) == 0) begin
                {m1_write, m1_read} = 2'($urandom_range(0, 3));
                m1_address = $urandom; m1_writedata = $urandom;
                m1_byteenable = 4'($urandom_range(0, 15));
            end
            s_waitrequest = ($urandom_range(0, 2) == 0);
            s_readdata = $urandom;
            step();
        end
        reset = 1'b1;
        idle_steps(8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
